float_norm_round: RTL and testbench

FLOAT_NORM_ROUND -- requirements
Module: float_norm_round

---
 rtl/float_norm_round.sv | 220 ++++++++++++++++++++++
 tb/tb_float_norm_round.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_norm_round.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// float_norm_round
//
// Normalise-and-round back end for a single-precision floating-point adder.
// Takes the raw sum from the adder stage and turns it into an IEEE-754 single
// result:
//   - a carry out of the hidden bit is fixed with one right shift;
//   - leading zeros are removed with one left shift per cycle;
//   - the result is rounded to nearest-even;
//   - overflow goes to infinity; anything that would go subnormal is flushed
//     to a signed zero.
// One operand is in flight at a time, with valid/ready on both sides.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : raw sum present from the adder stage
//   in_ready   : block can accept an operand (IDLE only)
//   in_sign    : sign of the raw sum
//   in_exp     : biased exponent of the raw sum
//   in_mant    : {carry, hidden, frac[22:0], guard, sticky}
//   out_valid  : out_res and the flags are valid (DONE only)
//   out_ready  : downstream takes the result
//   out_res    : IEEE-754 single result
//   out_zero   : result is a signed zero
//   out_ovf    : result overflowed to infinity
//   out_unf    : result underflowed and was flushed to zero
// -----------------------------------------------------------------------------
module float_norm_round (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [7:0]  in_exp,
   input  logic [26:0] in_mant,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic        out_zero,
   output logic        out_ovf,
   output logic        out_unf
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      ROUND,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   // armed stays low during reset and goes high on the first edge after it
   // is released. This keeps in_ready low while reset is asserted, even
   // though the state register already holds IDLE.
   logic              armed;
   logic              sign_r;
   logic signed [9:0] exp_r;
   logic [26:0]       mant_r;
   logic [31:0]       res_r;
   logic              zero_r;
   logic              ovf_r;
   logic              unf_r;

   logic        accept;
   logic        in_is_zero;
   logic        carry;
   logic        hidden;
   logic        exp_is0;
   logic        exp_le1;
   logic        flush;
   logic        rnd_inc;
   logic        rnd_co;
   logic [22:0] rnd_frac_sum;
   logic signed [9:0] rnd_exp;
   logic [22:0] rnd_frac;
   logic        rnd_ovf;

   assign accept     = (state == IDLE) && armed && in_valid;
   assign in_is_zero = (in_mant[26:1] == 26'd0);
   assign carry      = mant_r[26];
   assign hidden     = mant_r[25];
   assign exp_is0    = (exp_r == 10'sd0);
   assign exp_le1    = (exp_r <= 10'sd1);

   // Flush to zero once the value can no longer be normal. A hidden bit with
   // exponent 0 is already subnormal. With no hidden bit and exponent <= 1,
   // another left shift would push the exponent below 1.
   assign flush = !carry && ((hidden && exp_is0) || (!hidden && exp_le1));

   // Round to nearest-even on {hidden, frac}. ROUND is only reached with
   // hidden = 1, so a carry out of the 23-bit fraction is the same as a carry
   // out of the full significand. That carry means the significand became
   // 10.000..., so the fraction goes to 0 and the exponent goes up by 1.
   always_comb begin
      rnd_inc                = mant_r[1] & (mant_r[0] | mant_r[2]);
      {rnd_co, rnd_frac_sum} = {1'b0, mant_r[24:2]} + {23'd0, rnd_inc};
      rnd_exp                = rnd_co ? (exp_r + 10'sd1) : exp_r;
      rnd_frac               = rnd_co ? 23'd0 : rnd_frac_sum;
      rnd_ovf                = (rnd_exp >= 10'sd255);
   end

   // State register. Reset is asynchronous and may land mid-operation, in
   // which case the in-flight operand is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. SHIFT makes exactly one normalisation step per cycle.
   // A right shift always goes straight on to ROUND. A left shift stays in
   // SHIFT until the hidden bit is 1 or the value has to be flushed.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = in_is_zero ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (carry) begin
               state_next = ROUND;
            end else if (flush) begin
               state_next = DONE;
            end else if (hidden) begin
               state_next = ROUND;
            end else begin
               state_next = SHIFT;
            end
         end
         ROUND: begin
            state_next = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath registers. Each state updates only the fields it owns, so
   // out_res and the flags written on entry to DONE stay stable while
   // downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed  <= 1'b0;
         sign_r <= 1'b0;
         exp_r  <= 10'sd0;
         mant_r <= 27'd0;
         res_r  <= 32'd0;
         zero_r <= 1'b0;
         ovf_r  <= 1'b0;
         unf_r  <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  sign_r <= in_sign;
                  exp_r  <= $signed({2'b00, in_exp});
                  mant_r <= in_mant;
                  ovf_r  <= 1'b0;
                  unf_r  <= 1'b0;
                  if (in_is_zero) begin
                     res_r  <= {in_sign, 31'd0};
                     zero_r <= 1'b1;
                  end else begin
                     res_r  <= 32'd0;
                     zero_r <= 1'b0;
                  end
               end
            end
            SHIFT: begin
               if (carry) begin
                  // The bit shifted out joins the sticky bit, so rounding
                  // still sees that something below guard was nonzero.
                  mant_r <= {1'b0, mant_r[26:2], mant_r[1] | mant_r[0]};
                  exp_r  <= exp_r + 10'sd1;
               end else if (flush) begin
                  res_r  <= {sign_r, 31'd0};
                  zero_r <= 1'b1;
                  unf_r  <= 1'b1;
               end else if (!hidden) begin
                  mant_r <= {mant_r[25:0], 1'b0};
                  exp_r  <= exp_r - 10'sd1;
               end
            end
            ROUND: begin
               if (rnd_ovf) begin
                  res_r <= {sign_r, 8'hFF, 23'd0};
                  ovf_r <= 1'b1;
               end else begin
                  res_r <= {sign_r, rnd_exp[7:0], rnd_frac};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && armed;
   assign out_valid = (state == DONE);
   assign out_res   = res_r;
   assign out_zero  = zero_r;
   assign out_ovf   = ovf_r;
   assign out_unf   = unf_r;

endmodule

// File: tb/tb_float_norm_round.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_float_norm_round
//
// Self-checking bench for float_norm_round. Directed corner cases come first,
// then random operands compared against a closed-form reference model. The
// model finds the leading one of the mantissa, works out the normalised
// exponent and significand in one step, and rounds to nearest-even.
// -----------------------------------------------------------------------------
module tb_float_norm_round;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [26:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic        out_zero;
   logic        out_ovf;
   logic        out_unf;

   int checks = 0;
   int errors = 0;

   float_norm_round dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_zero  (out_zero),
      .out_ovf   (out_ovf),
      .out_unf   (out_unf)
   );

   // 10 ns clock; rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so that a stuck design still ends the run
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts the check and reports any failure
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
      end
   endtask

   // Reference model. Works from the value: find the leading one, normalise
   // in one step, then round to nearest-even. lat is -1 where the latency
   // is not checked.
   task automatic modelOp(input logic s, input logic [7:0] e, input logic [26:0] m,
                          output logic [31:0] res, output logic z, output logic o,
                          output logic u, output int lat);
      int          p;
      int          k;
      int          ee;
      logic [26:0] sh;
      logic [23:0] sig;
      logic        g;
      logic        st;
      logic [24:0] r;
      logic [7:0]  eb;
      res = 32'd0; z = 1'b0; o = 1'b0; u = 1'b0; lat = -1;
      if (m[26:1] == 26'd0) begin
         res = {s, 31'd0}; z = 1'b1; lat = 1;
      end else begin
         p = 0;
         for (int i = 0; i < 27; i++) if (m[i]) p = i;
         if (p == 26) begin
            ee = int'(e) + 1; sig = m[26:3]; g = m[2]; st = m[1] | m[0]; lat = 3;
         end else begin
            k = 25 - p; ee = int'(e) - k; sh = m << k;
            sig = sh[25:2]; g = sh[1]; st = sh[0]; lat = 3 + k;
         end
         if (p <= 25 && ee <= 0) begin
            res = {s, 31'd0}; z = 1'b1; u = 1'b1; lat = -1;
         end else begin
            r = {1'b0, sig} + {24'd0, g & (st | sig[0])};
            if (r[24]) begin
               ee = ee + 1;
               r  = 25'h0800000;
            end
            if (ee >= 255) begin
               res = {s, 8'hFF, 23'd0}; o = 1'b1;
            end else begin
               eb  = ee[7:0];
               res = {s, eb, r[22:0]};
            end
         end
      end
   endtask

   // Presents one operand and returns just after the edge that accepted it
   task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [26:0] m);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("accept_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Counts edges from the accept edge (inclusive) until out_valid appears
   task automatic waitResult(output int lat);
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Takes the result and checks that the block is back in IDLE on that edge
   task automatic consume(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
      checkOutput({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   // One full transaction checked against the given expectations
   task automatic runOp(input string tag, input logic s, input logic [7:0] e,
                        input logic [26:0] m, input logic [31:0] xres,
                        input logic xz, input logic xo, input logic xu, input int xlat);
      int lat;
      applyStimulus(s, e, m);
      waitResult(lat);
      checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, "_res"}, out_res, xres);
      checkOutput({tag, "_flags"}, {29'd0, out_zero, out_ovf, out_unf}, {29'd0, xz, xo, xu});
      checkOutput({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
      if (xlat > 0) begin
         checkOutput({tag, "_lat"}, 32'(lat), 32'(xlat));
      end
      consume(tag);
   endtask

   initial begin
      logic [31:0] xres;
      logic        xz;
      logic        xo;
      logic        xu;
      int          xlat;
      logic        s;
      logic [7:0]  e;
      logic [26:0] m;
      logic [31:0] tmp;
      int          pos;
      int          cat;
      int          lat;
      logic        stable;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 8'd0;
      in_mant   = 27'd0;
      out_ready = 1'b0;

      // While reset is held, every output is 0
      #2;
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_res", out_res, 32'd0);
      checkOutput("rst_flags", {29'd0, out_zero, out_ovf, out_unf}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_ready_before_edge", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("rel_ready_after_edge", {31'd0, in_ready}, 32'd1);

      // Directed corner cases
      runOp("carry_1p1", 1'b0, 8'd127, 27'd1 << 26, 32'h40000000, 1'b0, 1'b0, 1'b0, 3);
      runOp("left_2", 1'b0, 8'd127, 27'd1 << 23, 32'h3E800000, 1'b0, 1'b0, 1'b0, 5);
      runOp("rnd_co", 1'b0, 8'd127, {2'b01, 23'h7FFFFF, 2'b10}, 32'h40000000, 1'b0, 1'b0, 1'b0, 3);
      runOp("ovf", 1'b0, 8'd254, 27'd1 << 26, 32'h7F800000, 1'b0, 1'b1, 1'b0, 3);
      runOp("neg_zero", 1'b1, 8'd50, 27'd0, 32'h80000000, 1'b1, 1'b0, 1'b0, 1);
      runOp("unf", 1'b0, 8'd1, 27'd1 << 20, 32'h00000000, 1'b1, 1'b0, 1'b1, -1);
      runOp("tie_even", 1'b1, 8'd100, {2'b01, 23'h000000, 2'b10}, {1'b1, 8'd100, 23'd0}, 1'b0, 1'b0, 1'b0, 3);

      // Random operands against the reference model
      for (int i = 0; i < 40; i++) begin
         s   = 1'($urandom());
         cat = int'($urandom_range(9));
         if (cat < 6)      e = 8'($urandom_range(254, 30));
         else if (cat < 8) e = 8'($urandom_range(25, 0));
         else              e = 8'($urandom_range(255, 250));
         if ($urandom_range(9) == 0) begin
            m = 27'($urandom_range(1, 0));
         end else begin
            pos = int'($urandom_range(26, 1));
            tmp = ($urandom() & ((32'd1 << pos) - 32'd1)) | (32'd1 << pos);
            m   = tmp[26:0];
         end
         modelOp(s, e, m, xres, xz, xo, xu, xlat);
         runOp($sformatf("rnd%0d", i), s, e, m, xres, xz, xo, xu, xlat);
      end

      // Backpressure: result held stable and in_ready low while stalled
      applyStimulus(1'b0, 8'd127, 27'd1 << 26);
      waitResult(lat);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (out_res !== 32'h40000000 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
             {out_zero, out_ovf, out_unf} !== 3'b000)
            stable = 1'b0;
      end
      checkOutput("bp_stable", {31'd0, stable}, 32'd1);
      consume("bp");

      // Reset in the middle of a long left-shift sequence
      applyStimulus(1'b0, 8'd100, 27'd1 << 5);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("mid_rst_res", out_res, 32'd0);
      checkOutput("mid_rst_flags", {29'd0, out_zero, out_ovf, out_unf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_rel_ready", {31'd0, in_ready}, 32'd1);
      stable = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) stable = 1'b0;
      end
      checkOutput("mid_no_stale_valid", {31'd0, stable}, 32'd1);
      runOp("post_rst", 1'b1, 8'd127, 27'd1 << 23, 32'hBE800000, 1'b0, 1'b0, 1'b0, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
